// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encodings and the
// default filter length for a 50 MHz board (20 ms).
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        PRESSED    = 2'd2,
        REL_FILT   = 2'd3
    } state_e;

    localparam int unsigned CNT_MAX_50MHZ = 1000000;
    localparam int unsigned CNT_W_50MHZ   = 20;

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// level both flops take under reset.
module key_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Mechanical key debouncer: optional 2-flop front-end, then a four-state
// filter that accepts a transition only after CNT_MAX stable cycles.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_50MHZ,
    parameter int unsigned CNT_W      = CNT_W_50MHZ,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          SYNC_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic key_s;
    logic key_act;

    generate
        if (SYNC_EN) begin : g_sync
            // Reset to the released pin level so reset exit never looks like a press.
            key_sync_2ff #(
                .RST_VAL(ACTIVE_LOW)
            ) u_sync (
                .clk(clk),
                .rst(rst),
                .d  (key_in),
                .q  (key_s)
            );
        end else begin : g_nosync
            assign key_s = key_in;
        end
    endgenerate

    assign key_act = key_s ^ ACTIVE_LOW;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             busy_q,    busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (key_act) begin
                    state_d = PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (!key_act) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                level_d = 1'b1;
                if (!key_act) begin
                    state_d = REL_FILT;
                    cnt_d   = '0;
                end
            end
            REL_FILT: begin
                if (key_act) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        busy_d = (state_d == PRESS_FILT) || (state_d == REL_FILT);
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_busy    = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (CNT_MAX=8, active-low key, synchronizer on),
// checked cycle by cycle against a run-length model of the filter rules.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int CM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b1;
    logic key_level, key_press, key_release, key_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] obs, exp;

    key_debounce #(
        .CNT_MAX   (CM),
        .CNT_W     (4),
        .ACTIVE_LOW(1'b1),
        .SYNC_EN   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_busy   (key_busy)
    );

    always #5 clk = ~clk;

    // Reference: two-sample input delay, then a transition is accepted once
    // CM+1 consecutive samples disagree with the current debounced level.
    logic m_s1, m_s2, m_act, m_level, m_press, m_rel;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0;
            m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
        end else begin
            m_act   = ~m_s2;
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (m_act != m_level) begin
                m_run++;
                if (m_run == CM + 1) begin
                    m_level = m_act;
                    m_press = m_act;
                    m_rel   = ~m_act;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    end

    function automatic logic [3:0] exp_vec();
        return {m_level, m_press, m_rel, (m_run != 0)};
    endfunction

    assign obs = {key_level, key_press, key_release, key_busy};

    task automatic test_reset();
        rst = 1'b1;
        key_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_held cyc %0d: got %b want 0000", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== 4'b0000 || obs !== exp) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b want 0000", i, obs);
            end
        end
        n_tests++;
        if (dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_clean_press();
        int press_cnt = 0;
        int busy_cnt  = 0;
        int press_idx = -1;
        key_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_press cyc %0d: got %b want %b", i, obs, exp);
            end
            if (key_press) begin press_cnt++; press_idx = i; end
            if (key_busy) busy_cnt++;
        end
        n_tests++;
        if (press_cnt != 1 || press_idx != 10) begin
            n_fail++;
            $display("FAIL clean_press_pulse: got count %0d at %0d want 1 at 10", press_cnt, press_idx);
        end
        n_tests++;
        if (busy_cnt != CM) begin
            n_fail++;
            $display("FAIL clean_press_busy: got %0d cycles want %0d", busy_cnt, CM);
        end
        n_tests++;
        if (key_level !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_press_level: got %b want 1", key_level);
        end
    endtask

    task automatic test_release_bounce();
        int rel_cnt = 0;
        int press_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            key_in = (i >= 3 && i < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL release_bounce cyc %0d: got %b want %b", i, obs, exp);
            end
            if (key_release) rel_cnt++;
            if (key_press) press_cnt++;
        end
        n_tests++;
        if (rel_cnt != 1 || press_cnt != 0 || key_level !== 1'b0) begin
            n_fail++;
            $display("FAIL release_bounce_pulses: got rel %0d press %0d level %b want 1 0 0",
                     rel_cnt, press_cnt, key_level);
        end
    endtask

    task automatic test_press_bounce();
        int press_cnt = 0;
        int level_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            key_in = (i < 30 && ((i / 3) % 2 == 0)) ? 1'b0 : 1'b1;
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL press_bounce cyc %0d: got %b want %b", i, obs, exp);
            end
            if (key_press) press_cnt++;
            if (key_level) level_cnt++;
        end
        n_tests++;
        if (press_cnt != 0 || level_cnt != 0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL press_bounce_idle: got press %0d level %0d state %0d want 0 0 %0d",
                     press_cnt, level_cnt, dut.state_q, IDLE);
        end
    endtask

    task automatic test_last_cycle_bounce();
        int press_cnt = 0;
        int press_idx = -1;
        for (int i = 0; i < 32; i++) begin
            key_in = (i < 8 || i >= 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL last_bounce cyc %0d: got %b want %b", i, obs, exp);
            end
            if (i == 9) begin
                n_tests++;
                if (dut.cnt_q !== 4'd7 || key_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last_bounce_setup: got cnt %0d busy %b want 7 1", dut.cnt_q, key_busy);
                end
            end
            if (key_press) begin press_cnt++; press_idx = i; end
        end
        n_tests++;
        if (press_cnt != 1 || press_idx != 22) begin
            n_fail++;
            $display("FAIL last_bounce_restart: got count %0d at %0d want 1 at 22", press_cnt, press_idx);
        end
    endtask

    task automatic test_reset_mid_release();
        bit found = 1'b0;
        int pulse_cnt = 0;
        key_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_lead cyc %0d: got %b want %b", i, obs, exp);
            end
            if (m_level && m_run == 5) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found || dut.cnt_q !== 4'd4) begin
            n_fail++;
            $display("FAIL reset_mid_reach: got found %0d cnt %0d want 1 4", found, dut.cnt_q);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 0000", obs);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            exp = exp_vec();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, obs, exp);
            end
            if (key_press || key_release || key_level) pulse_cnt++;
        end
        n_tests++;
        if (pulse_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulse_cnt);
        end
    endtask

    task automatic test_random();
        int remaining = 400;
        while (remaining > 0) begin
            logic v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int j = 0; j < len && remaining > 0; j++) begin
                key_in = v;
                @(negedge clk);
                exp = exp_vec();
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got %b want %b", 400 - remaining, obs, exp);
                end
                remaining--;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_press_bounce();
        test_last_cycle_bounce();
        test_reset_mid_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
